// File: rtl/seq_onehot_decoder.sv
// Registered binary-to-one-hot decoder with two modes: DECODE, where an index is
// accepted over a valid/ready handshake, and SCAN, a free-running walk with programmable dwell.
module seq_onehot_decoder #(
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned NUM_OUT = 16,
    parameter int unsigned DWELL   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] out,
    output logic               out_valid,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               range_err,
    output logic               wrap
);

    localparam int unsigned          CNT_W      = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0]     DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]     SEL_LAST   = SEL_W'(NUM_OUT - 1);
    localparam logic [NUM_OUT-1:0]   FIRST_HOT  = {{(NUM_OUT - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StHold, StScan} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   dwell_cnt_q;

    logic               transfer;
    logic               sel_in_range;
    logic [NUM_OUT-1:0] sel_onehot;
    logic               scan_last;
    logic [SEL_W-1:0]   scan_next;
    logic [NUM_OUT-1:0] scan_onehot;

    assign in_ready     = en & ~mode;
    assign transfer     = in_valid & in_ready;
    assign sel_in_range = 32'(sel) < NUM_OUT;
    assign scan_last    = (cur_sel == SEL_LAST);
    assign scan_next    = scan_last ? '0 : cur_sel + SEL_W'(1);

    always_comb begin
        sel_onehot  = '0;
        scan_onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            sel_onehot[i]  = (sel == SEL_W'(i));
            scan_onehot[i] = (scan_next == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            dwell_cnt_q <= '0;
            out         <= '0;
            out_valid   <= 1'b0;
            cur_sel     <= '0;
            range_err   <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            range_err <= 1'b0;
            wrap      <= 1'b0;
            if (!en) begin
                // cur_sel is deliberately retained while disabled
                state_q     <= StIdle;
                dwell_cnt_q <= '0;
                out         <= '0;
                out_valid   <= 1'b0;
            end else if (mode) begin
                if (state_q != StScan) begin
                    state_q     <= StScan;
                    dwell_cnt_q <= '0;
                    out         <= FIRST_HOT;
                    out_valid   <= 1'b1;
                    cur_sel     <= '0;
                end else if (dwell_cnt_q == DWELL_LAST) begin
                    dwell_cnt_q <= '0;
                    out         <= scan_onehot;
                    cur_sel     <= scan_next;
                    wrap        <= scan_last;
                end else begin
                    dwell_cnt_q <= dwell_cnt_q + CNT_W'(1);
                end
            end else if (transfer) begin
                if (sel_in_range) begin
                    state_q   <= StHold;
                    out       <= sel_onehot;
                    out_valid <= 1'b1;
                    cur_sel   <= sel;
                end else begin
                    state_q   <= StIdle;
                    out       <= '0;
                    out_valid <= 1'b0;
                    range_err <= 1'b1;
                end
            end else if (state_q == StScan) begin
                // leaving SCAN freezes the current index in HOLD
                state_q <= StHold;
            end
        end
    end

    ap_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(out));
    ap_valid:   assert property (@(posedge clk) disable iff (!rst_n) out_valid == (out != '0));
    ap_range:   assert property (@(posedge clk) disable iff (!rst_n) 32'(cur_sel) < NUM_OUT);

endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Randomised plus directed bench for seq_onehot_decoder; a cycle-level reference model
// queues expected outputs and a negedge monitor pops and compares them.
module tb_seq_onehot_decoder;

    localparam int SEL_W   = 4;
    localparam int NUM_OUT = 10;
    localparam int DWELL   = 3;

    logic               clk      = 1'b0;
    logic               rst_n    = 1'b0;
    logic               en       = 1'b0;
    logic               mode     = 1'b0;
    logic               in_valid = 1'b0;
    logic [SEL_W-1:0]   sel      = '0;
    logic               in_ready;
    logic [NUM_OUT-1:0] out;
    logic               out_valid;
    logic [SEL_W-1:0]   cur_sel;
    logic               range_err;
    logic               wrap;

    seq_onehot_decoder #(
        .SEL_W  (SEL_W),
        .NUM_OUT(NUM_OUT),
        .DWELL  (DWELL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .out      (out),
        .out_valid(out_valid),
        .cur_sel  (cur_sel),
        .range_err(range_err),
        .wrap     (wrap)
    );

    typedef struct packed {
        logic [NUM_OUT-1:0] out;
        logic               valid;
        logic [SEL_W-1:0]   cur;
        logic               rerr;
        logic               wrap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Model: 0 = off, 1 = holding m_cur, 2 = scanning; m_pos counts cycles since scan entry
    int m_st  = 0;
    int m_cur = 0;
    int m_pos = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        exp_t e;
        e = '0;
        if (!rst_n) begin
            m_st = 0; m_cur = 0; m_pos = 0;
        end else if (!en) begin
            m_st = 0;
        end else if (mode) begin
            if (m_st != 2) begin
                m_st = 2; m_pos = 0;
            end else begin
                m_pos++;
            end
            m_cur  = (m_pos / DWELL) % NUM_OUT;
            e.wrap = (m_pos != 0) && ((m_pos % (DWELL * NUM_OUT)) == 0);
        end else if (in_valid) begin
            if (int'(sel) < NUM_OUT) begin
                m_st = 1; m_cur = int'(sel);
            end else begin
                m_st = 0; e.rerr = 1'b1;
            end
        end else if (m_st == 2) begin
            m_st = 1;
        end
        e.cur   = SEL_W'(m_cur);
        e.valid = (m_st != 0);
        e.out   = (m_st != 0) ? ({{(NUM_OUT - 1){1'b0}}, 1'b1} << m_cur) : '0;
        exp_q.push_back(e);
    end

    always @(negedge rst_n) begin
        exp_q.delete();
        m_st = 0; m_cur = 0; m_pos = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (exp_q.size() > 0) begin
            e         = exp_q.pop_front();
            got.out   = out;
            got.valid = out_valid;
            got.cur   = cur_sel;
            got.rerr  = range_err;
            got.wrap  = wrap;
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL cycle_outputs t=%0t: got out=%h valid=%b cur=%0d rerr=%b wrap=%b, expected out=%h valid=%b cur=%0d rerr=%b wrap=%b",
                         $time, got.out, got.valid, got.cur, got.rerr, got.wrap,
                         e.out, e.valid, e.cur, e.rerr, e.wrap);
            end
        end
        checks++;
        if (in_ready !== (en & ~mode)) begin
            fails++;
            $display("FAIL in_ready t=%0t: got %b, expected %b", $time, in_ready, en & ~mode);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        en    = 1'b1;

        // Decode sweep, includes out-of-range indices 10..15
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            sel      = SEL_W'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();

        // Out-of-range then top index
        in_valid = 1'b1; sel = 4'd12; tick();
        sel = 4'd9; tick();
        in_valid = 1'b0; tick();

        // Enable drop: transfer while disabled is ignored
        in_valid = 1'b1; sel = 4'd5; tick();
        in_valid = 1'b0; tick();
        en = 1'b0; tick();
        in_valid = 1'b1; sel = 4'd3; tick();
        in_valid = 1'b0; en = 1'b1; repeat (3) tick();

        // Scan through more than two full wraps
        mode = 1'b1;
        repeat (2 * DWELL * NUM_OUT + 4) tick();

        // Re-enter scan, stop at index 6 and freeze
        mode = 1'b0; tick();
        mode = 1'b1;
        repeat (6 * DWELL + 1) tick();
        mode = 1'b0; repeat (3) tick();

        // Re-enter scan, stop at index 6 with a transfer in the switch cycle
        mode = 1'b1;
        repeat (6 * DWELL + 1) tick();
        mode = 1'b0; in_valid = 1'b1; sel = 4'd2; tick();
        in_valid = 1'b0; repeat (2) tick();

        // Reset mid-scan, between edges
        mode = 1'b1;
        repeat (DWELL + 2) tick();
        #1 rst_n = 1'b0;
        #1;
        check("reset_out", int'(out), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_cur_sel", int'(cur_sel), 0);
        check("reset_pulses", int'({range_err, wrap}), 0);
        #1 rst_n = 1'b1;
        repeat (DWELL * NUM_OUT + 2) tick();

        // Random traffic; mode is sticky so scans run long enough to wrap
        for (int n = 0; n < 800; n++) begin
            en       = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            in_valid = $urandom_range(0, 1) == 1;
            sel      = SEL_W'($urandom_range(0, 15));
            tick();
        end

        in_valid = 1'b0;
        tick();
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
